store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Store-side counterpart of the writeback data path: carries register data out to data memory on sb/sh/sw.
- The writeback path carries memory data back into the register file.
- Sits between the MEM stage and a data memory that may take several cycles per write.
- Provides a DEPTH-entry FIFO that:
  - byte-lane aligns store data and generates byte enables;
  - stalls the pipeline when full;
  - flags loads that hit a pending store.

Parameters:
- DEPTH, 4, number of buffered stores (power of two, ≥2)
- PTR_W, 2, log2(DEPTH)

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- St_Valid  input  1  MEM stage presents a store this cycle
- St_Addr  input  32  byte address of store
- St_Data  input  32  register data (rt), value in low bits
- St_Size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
- St_Stall  output  1  buffer full; MEM stage must hold the store
- Misalign_Err  output  1  one-cycle pulse: accepted-cycle store was misaligned or reserved size
- Ld_Addr  input  32  byte address of load currently in MEM
- Ld_Hit  output  1  some pending entry matches Ld_Addr[31:2]
- Mem_Write  output  1  head entry valid, write request to memory
- Mem_Addr  output  32  word-aligned address {addr[31:2],2'b00}
- Mem_WData  output  32  lane-aligned write data
- Mem_BE  output  4  byte enables, bit i = byte lane i (little-endian)
- Mem_Ready  input  1  memory accepts the current write this cycle
- Empty  output  1  no pending stores

Behaviour:
- Reset (synchronous, reset high at a clock edge):
  - read/write pointers and count cleared;
  - all entry valid bits cleared;
  - Misalign_Err=0.
  - Outputs after reset: Mem_Write=0, St_Stall=0, Ld_Hit=0, Empty=1, Mem_Addr/Mem_WData/Mem_BE=0.
  - Reset mid-transaction discards all pending stores; Mem_Write drops in the cycle after the reset edge.
- Push:
  - occurs when St_Valid && !St_Stall && aligned;
  - the entry is written at the edge;
  - head outputs reflect it the next cycle if the buffer was empty (latency 1).
- Alignment and lane placement:
  - byte: any address. BE = 1<<addr[1:0]. Data = {4{St_Data[7:0]}}.
  - half: addr[0] must be 0. BE = addr[1] ? 1100 : 0011. Data = {2{St_Data[15:0]}}.
  - word: addr[1:0] must be 00. BE = 1111. Data = St_Data.
  - Misaligned or Size=11: store dropped (no push); Misalign_Err pulses high for one cycle (registered, cycle after the edge).
- Pop:
  - Mem_Write = !Empty;
  - Mem_Addr/Mem_WData/Mem_BE come from the head entry and are held stable while Mem_Write && !Mem_Ready;
  - the entry retires at an edge where Mem_Write && Mem_Ready.
- Count and full:
  - count in 0..DEPTH;
  - St_Stall = (count==DEPTH), combinational from registered count;
  - no same-cycle push-through when full, even if Mem_Ready=1 that cycle.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- Pointer wrap: pointers are PTR_W bits and wrap modulo DEPTH; ordering is strictly FIFO.
- Ld_Hit:
  - combinational OR over valid entries of (entry_addr[31:2]==Ld_Addr[31:2]);
  - the store being pushed this same cycle is not included;
  - the hazard unit stalls the load while Ld_Hit=1.
- Empty = (count==0).

Test Plan:
- Reset then idle:
  - expected: Empty=1, Mem_Write=0, St_Stall=0.
  - then push sw addr 0x100 data 0xDEADBEEF.
  - expected next cycle: Mem_Write=1, Mem_Addr=0x100, Mem_WData=0xDEADBEEF, BE=1111.
  - Mem_Ready=1 one cycle → Empty=1.
- Lane alignment:
  - sb addr 0x203 data 0x000000A5 → BE=1000, WData=0xA5A5A5A5, Mem_Addr=0x200.
  - sh addr 0x202 data 0x00001234 → BE=1100, WData=0x12341234.
- Fill and stall:
  - Mem_Ready=0, push 4 words 0x10..0x1C → St_Stall=1 after the 4th.
  - a 5th push is held.
  - Mem_Ready=1 for 1 cycle → St_Stall=0, head advances to 0x14.
  - order out must be 0x10, 0x14, 0x18, 0x1C.
- Simultaneous push/pop across wrap:
  - keep count=2 with push and Mem_Ready=1 every cycle for 10 cycles.
  - expected: count stays 2, addresses retire in push order, no loss or duplication.
- Misaligned:
  - sw addr 0x102 → no push, Misalign_Err=1 for exactly one cycle, Empty unchanged.
  - sh addr 0x101 → same.
  - St_Size=11 → same.
- Load hit and reset:
  - pending sb 0x305 with Mem_Ready=0.
  - Ld_Addr=0x304 → Ld_Hit=1.
  - Ld_Addr=0x308 → Ld_Hit=0.
  - assert reset one cycle → next cycle Empty=1, Mem_Write=0, Ld_Hit=0.

Source files
------------

// File: rtl/store_buffer_if.sv
// Store buffer bus: MEM-stage store/load side plus data-memory write side.
// The master drives stores, loads and memory ready; the slave is the buffer.
interface store_buffer_if;
   logic        St_Valid;
   logic [31:0] St_Addr;
   logic [31:0] St_Data;
   logic [1:0]  St_Size;
   logic        St_Stall;
   logic        Misalign_Err;
   logic [31:0] Ld_Addr;
   logic        Ld_Hit;
   logic        Mem_Write;
   logic [31:0] Mem_Addr;
   logic [31:0] Mem_WData;
   logic [3:0]  Mem_BE;
   logic        Mem_Ready;
   logic        Empty;

   modport master (
      output St_Valid, St_Addr, St_Data, St_Size, Ld_Addr, Mem_Ready,
      input  St_Stall, Misalign_Err, Ld_Hit, Mem_Write, Mem_Addr, Mem_WData,
             Mem_BE, Empty
   );

   modport slave (
      input  St_Valid, St_Addr, St_Data, St_Size, Ld_Addr, Mem_Ready,
      output St_Stall, Misalign_Err, Ld_Hit, Mem_Write, Mem_Addr, Mem_WData,
             Mem_BE, Empty
   );
endinterface

// File: rtl/store_buffer.sv
// DEPTH-entry store FIFO between MEM and data memory: lane-aligns sb/sh/sw,
// stalls MEM when full, and flags loads whose word matches a pending store.
module store_buffer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 2
) (
   input logic           clk,
   input logic           reset,
   store_buffer_if.slave bus
);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [29:0] waddr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } sb_entry_t;

   sb_entry_t          ent_q [DEPTH];
   logic [DEPTH-1:0]   vld_q, vld_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;

   logic               full_c, empty_c, aligned_c, accept_c, push_c, pop_c, hit_c;
   logic [3:0]         be_c;
   logic [31:0]        wdata_c;
   sb_entry_t          head_c;
   logic               unused_c;

   assign unused_c = ^bus.Ld_Addr[1:0];

   assign full_c   = (cnt_q == CNT_W'(DEPTH));
   assign empty_c  = (cnt_q == '0);
   assign accept_c = bus.St_Valid && !full_c;
   assign push_c   = accept_c && aligned_c;
   assign pop_c    = !empty_c && bus.Mem_Ready;

   // Lane placement and alignment check for the incoming store.
   always_comb begin
      aligned_c = 1'b0;
      be_c      = 4'b0000;
      wdata_c   = 32'h0;
      unique case (bus.St_Size)
         2'b00: begin
            aligned_c = 1'b1;
            be_c      = 4'b0001 << bus.St_Addr[1:0];
            wdata_c   = {4{bus.St_Data[7:0]}};
         end
         2'b01: begin
            aligned_c = !bus.St_Addr[0];
            be_c      = bus.St_Addr[1] ? 4'b1100 : 4'b0011;
            wdata_c   = {2{bus.St_Data[15:0]}};
         end
         2'b10: begin
            aligned_c = (bus.St_Addr[1:0] == 2'b00);
            be_c      = 4'b1111;
            wdata_c   = bus.St_Data;
         end
         default: aligned_c = 1'b0;
      endcase
   end

   always_comb begin
      vld_d    = vld_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      err_d    = accept_c && !aligned_c;
      if (push_c) begin
         vld_d[wr_ptr_q] = 1'b1;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
         vld_d[rd_ptr_q] = 1'b0;
         rd_ptr_d        = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push_c, pop_c})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         vld_q    <= vld_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   // Payload storage needs no reset; validity is tracked by vld_q/cnt_q.
   always_ff @(posedge clk) begin
      if (push_c) begin
         ent_q[wr_ptr_q] <= '{waddr: bus.St_Addr[31:2], wdata: wdata_c, be: be_c};
      end
   end

   always_comb begin
      hit_c = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (vld_q[i] && (ent_q[i].waddr == bus.Ld_Addr[31:2])) begin
            hit_c = 1'b1;
         end
      end
   end

   assign head_c = ent_q[rd_ptr_q];

   assign bus.St_Stall     = full_c;
   assign bus.Misalign_Err = err_q;
   assign bus.Ld_Hit       = hit_c;
   assign bus.Empty        = empty_c;
   assign bus.Mem_Write    = !empty_c;
   assign bus.Mem_Addr     = empty_c ? 32'h0 : {head_c.waddr, 2'b00};
   assign bus.Mem_WData    = empty_c ? 32'h0 : head_c.wdata;
   assign bus.Mem_BE       = empty_c ? 4'h0  : head_c.be;
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: a queue-based reference model checked every cycle,
// plus directed stores with hand-computed literal expectations.
module tb_store_buffer;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   store_buffer_if bus ();

   store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } exp_t;

   exp_t        mq[$];
   logic [31:0] dut_ret[$];
   logic        exp_err = 1'b0;
   bit          model_on = 1'b0;
   int          n_chk = 0;
   int          n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected memory-side image of a store; returns 0 when it must be dropped.
   function automatic bit lane(input logic [31:0] a, input logic [31:0] d,
                               input logic [1:0] sz, output exp_t e);
      bit ok;
      e.addr = a & ~32'h3;
      e.data = 32'h0;
      e.be   = 4'h0;
      ok     = 1'b0;
      case (sz)
         2'd0: begin ok = 1'b1;          e.be = 4'(1 << (a % 4));               e.data = {4{d[7:0]}}; end
         2'd1: begin ok = (a % 2 == 0);  e.be = (a % 4 == 2) ? 4'hC : 4'h3;     e.data = {2{d[15:0]}}; end
         2'd2: begin ok = (a % 4 == 0);  e.be = 4'hF;                           e.data = d; end
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   always @(posedge clk) begin
      bit   pop, acc, ok;
      exp_t e;
      if (reset) begin
         mq.delete();
         exp_err  = 1'b0;
         model_on = 1'b1;
      end else if (model_on) begin
         pop     = (mq.size() > 0) && bus.Mem_Ready;
         acc     = bus.St_Valid && (mq.size() < 4);
         ok      = lane(bus.St_Addr, bus.St_Data, bus.St_Size, e);
         exp_err = acc && !ok;
         if (pop) void'(mq.pop_front());
         if (acc && ok) mq.push_back(e);
      end
   end

   always @(posedge clk) begin
      if (!reset && bus.Mem_Write === 1'b1 && bus.Mem_Ready) dut_ret.push_back(bus.Mem_Addr);
   end

   always @(negedge clk) begin
      int   n;
      logic hit;
      if (model_on) begin
         n   = mq.size();
         hit = 1'b0;
         foreach (mq[i]) if (mq[i].addr[31:2] == bus.Ld_Addr[31:2]) hit = 1'b1;
         chk("m_empty",     32'(bus.Empty),        32'(n == 0));
         chk("m_mem_write", 32'(bus.Mem_Write),    32'(n != 0));
         chk("m_stall",     32'(bus.St_Stall),     32'(n == 4));
         chk("m_ld_hit",    32'(bus.Ld_Hit),       32'(hit));
         chk("m_misalign",  32'(bus.Misalign_Err), 32'(exp_err));
         chk("m_addr",  bus.Mem_Addr,       (n != 0) ? mq[0].addr : 32'h0);
         chk("m_wdata", bus.Mem_WData,      (n != 0) ? mq[0].data : 32'h0);
         chk("m_be",    32'(bus.Mem_BE),    (n != 0) ? 32'(mq[0].be) : 32'h0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
      bus.St_Valid = 1'b1;
      bus.St_Addr  = a;
      bus.St_Data  = d;
      bus.St_Size  = sz;
      step();
      bus.St_Valid = 1'b0;
   endtask

   task automatic drain();
      bus.Mem_Ready = 1'b1;
      for (int i = 0; i < 20 && bus.Empty !== 1'b1; i++) step();
      bus.Mem_Ready = 1'b0;
      chk("drain_empty", 32'(bus.Empty), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset         = 1'b1;
      bus.St_Valid  = 1'b0;
      bus.St_Addr   = 32'h0;
      bus.St_Data   = 32'h0;
      bus.St_Size   = 2'b10;
      bus.Ld_Addr   = 32'hFFFF_FFF0;
      bus.Mem_Ready = 1'b0;
      step();
      step();
      reset = 1'b0;
      chk("rst_empty", 32'(bus.Empty),     32'd1);
      chk("rst_write", 32'(bus.Mem_Write), 32'd0);
      chk("rst_stall", 32'(bus.St_Stall),  32'd0);

      push(32'h100, 32'hDEADBEEF, 2'b10);
      chk("sw_write", 32'(bus.Mem_Write), 32'd1);
      chk("sw_addr",  bus.Mem_Addr,       32'h100);
      chk("sw_wdata", bus.Mem_WData,      32'hDEADBEEF);
      chk("sw_be",    32'(bus.Mem_BE),    32'hF);
      bus.Mem_Ready = 1'b1;
      step();
      bus.Mem_Ready = 1'b0;
      chk("sw_retired_empty", 32'(bus.Empty), 32'd1);

      push(32'h203, 32'h000000A5, 2'b00);
      chk("sb_be",    32'(bus.Mem_BE), 32'h8);
      chk("sb_wdata", bus.Mem_WData,   32'hA5A5A5A5);
      chk("sb_addr",  bus.Mem_Addr,    32'h200);
      drain();
      push(32'h202, 32'h00001234, 2'b01);
      chk("sh_be",    32'(bus.Mem_BE), 32'hC);
      chk("sh_wdata", bus.Mem_WData,   32'h12341234);
      drain();

      dut_ret.delete();
      for (int i = 0; i < 4; i++) push(32'h10 + 32'(4 * i), 32'hA000 + 32'(i), 2'b10);
      chk("full_stall", 32'(bus.St_Stall), 32'd1);
      bus.St_Valid = 1'b1;
      bus.St_Addr  = 32'h20;
      bus.St_Data  = 32'hA004;
      bus.St_Size  = 2'b10;
      step();
      chk("held_stall", 32'(bus.St_Stall), 32'd1);
      chk("held_head",  bus.Mem_Addr,      32'h10);
      bus.Mem_Ready = 1'b1;
      step();
      bus.Mem_Ready = 1'b0;
      chk("pop_unstall", 32'(bus.St_Stall), 32'd0);
      chk("pop_head",    bus.Mem_Addr,      32'h14);
      step();
      bus.St_Valid = 1'b0;
      chk("refill_stall", 32'(bus.St_Stall), 32'd1);
      drain();
      chk("fill_ret_n", 32'(dut_ret.size()), 32'd5);
      for (int i = 0; i < 5 && i < dut_ret.size(); i++)
         chk($sformatf("fill_ret_%0d", i), dut_ret[i], 32'h10 + 32'(4 * i));

      dut_ret.delete();
      push(32'h400, 32'hB000, 2'b10);
      push(32'h404, 32'hB001, 2'b10);
      bus.Mem_Ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         push(32'h408 + 32'(4 * i), 32'hB002 + 32'(i), 2'b10);
         chk($sformatf("wrap_head_%0d", i), bus.Mem_Addr, 32'h404 + 32'(4 * i));
      end
      bus.Mem_Ready = 1'b0;
      drain();
      chk("wrap_ret_n", 32'(dut_ret.size()), 32'd12);
      for (int i = 0; i < 12 && i < dut_ret.size(); i++)
         chk($sformatf("wrap_ret_%0d", i), dut_ret[i], 32'h400 + 32'(4 * i));

      push(32'h102, 32'h1, 2'b10);
      chk("mis_sw_err",   32'(bus.Misalign_Err), 32'd1);
      chk("mis_sw_empty", 32'(bus.Empty),        32'd1);
      step();
      chk("mis_sw_pulse", 32'(bus.Misalign_Err), 32'd0);
      push(32'h101, 32'h2, 2'b01);
      chk("mis_sh_err",   32'(bus.Misalign_Err), 32'd1);
      chk("mis_sh_empty", 32'(bus.Empty),        32'd1);
      step();
      chk("mis_sh_pulse", 32'(bus.Misalign_Err), 32'd0);
      push(32'h100, 32'h3, 2'b11);
      chk("mis_rsv_err",   32'(bus.Misalign_Err), 32'd1);
      chk("mis_rsv_empty", 32'(bus.Empty),        32'd1);
      step();
      chk("mis_rsv_pulse", 32'(bus.Misalign_Err), 32'd0);

      push(32'h305, 32'h77, 2'b00);
      bus.Ld_Addr = 32'h304;
      #1 chk("ld_hit_304",  32'(bus.Ld_Hit), 32'd1);
      bus.Ld_Addr = 32'h308;
      #1 chk("ld_miss_308", 32'(bus.Ld_Hit), 32'd0);
      bus.Ld_Addr = 32'h304;
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst2_empty", 32'(bus.Empty),     32'd1);
      chk("rst2_write", 32'(bus.Mem_Write), 32'd0);
      chk("rst2_hit",   32'(bus.Ld_Hit),    32'd0);
      chk("rst2_addr",  bus.Mem_Addr,       32'h0);
      step();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
